violated_timing_tracker: RTL and testbench
==========================================

Name: violated_timing_tracker

Overview:
- Multi-channel, parametrised successor to the single-channel violated-timing counter in the scheduler.
- Tracks NUM_TIMERS independent DRAM timing constraints (e.g. tRCD, tRAS, tRP, tWR; nominal or deliberately reduced values) in DRAM-cycle units, across fabric clocks carrying NCK_PER_CLK DRAM slots each.
- Per timer, reports whether the constraint is satisfied in the current fabric cycle and the earliest satisfying slot.
- Also reports an aggregate earliest slot, which the scheduler uses for multi-constraint commands.

Parameters:
- NCK_PER_CLK, 4, DRAM command slots per fabric clock; power of two, ≥2.
- NUM_TIMERS, 4, independent timing channels.
- TP_W, 6, width of the timing-parameter input in DRAM cycles; must satisfy TP_W ≥ SLOT_W.
- RESTART_MODE, 0, 0 = a new start overwrites a pending count; 1 = the longer of pending and new count is kept.
- Derived SLOT_W = CLOG2(NCK_PER_CLK).

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset; synchronous, active-high.
- start, in, NUM_TIMERS: per-timer arm strobe; the command constraining timer i issued this fabric cycle.
- slot, in, NUM_TIMERS*SLOT_W: per-timer issue slot of that command, packed with timer i at [i*SLOT_W +: SLOT_W].
- tp, in, NUM_TIMERS*TP_W: per-timer constraint length in DRAM cycles, packed the same way.
- done, out, NUM_TIMERS: timer i is satisfied at or before some slot of the current fabric cycle.
- offset, out, NUM_TIMERS*SLOT_W: earliest legal slot this cycle for timer i; 0 when not done.
- all_done, out, 1: AND of done.
- max_offset, out, SLOT_W: maximum offset over all timers when all_done=1; otherwise 0.

Behaviour:
- Each timer holds a remaining count r, TP_W+1 bits wide.
  - r is measured in DRAM cycles from slot 0 of the current fabric cycle.
- Reset:
  - r=0 for all timers, so done=all 1s, offset=0, all_done=1, max_offset=0.
  - rst has priority over start.
  - rst asserted mid-count clears every pending count within one cycle.
- Load value:
  - L = slot + tp − NCK_PER_CLK, saturating at 0.
  - The sum is computed at TP_W+1 bits and cannot overflow.
  - Subtracting NCK_PER_CLK accounts for the fabric cycle in which the command issued.
- Per clock, with rst=0:
  - dec = (r ≥ NCK_PER_CLK) ? r − NCK_PER_CLK : 0.
  - start[i]=0: r ← dec.
  - start[i]=1 and RESTART_MODE=0: r ← L.
  - start[i]=1 and RESTART_MODE=1: r ← max(dec, L).
- Outputs:
  - done[i] = (r < NCK_PER_CLK), registered-state combinational.
  - offset[i] = r[SLOT_W-1:0] when done[i], else 0.
- Latency: start is visible on done/offset one clock later, never in the same cycle.
- Boundaries:
  - tp=0 or slot+tp ≤ NCK_PER_CLK gives done=1 and offset=0 the next cycle.
  - tp at maximum with slot=NCK_PER_CLK−1 counts correctly; no wrap.
  - start on an already-done timer behaves as a fresh load in both modes.
  - Simultaneous starts on different timers are independent.
  - Once r reaches 0 it stays there.
- No state machine beyond the per-timer counter; the aggregate outputs are purely combinational over the counter states.

Decomposition:
- CLOG2 comes from the shared util.vh.
- Restart-mode encodings (RESTART_OVERWRITE=0, RESTART_MAX=1) go in a shared scheduler constants header.
- Sub-module violated_timing_timer implements one channel: clk, rst, start, slot, tp → done, offset.
  - The top instantiates it NUM_TIMERS times in a generate loop and adds the all_done/max_offset reduction.

Test Plan:
- Reset, N=4 → done=4'b1111, offset all 0, all_done=1, max_offset=0.
- Timer0: start, slot=1, tp=6 (L=3) → next cycle done[0]=1, offset[0]=3; cycle after: offset[0]=0, done[0]=1.
- Timer1: slot=2, tp=11 (L=9) → done[1]=0, 0, 1 over cycles +1, +2, +3; offset[1]=1 at +3, 0 at +4.
- Timer2: slot=2, tp=1 (saturates to 0) → done[2]=1 and offset[2]=0 at +1; same for tp=0.
- Timer0: start slot=0, tp=11 (r=7 next cycle), then start slot=0, tp=2 → RESTART_MODE=1: r=3, done=1, offset=3; RESTART_MODE=0: r=0, offset=0.
- Timer0 offset 3, timer1 offset 1, others idle → all_done=1, max_offset=3.
  - Then arm timer3 with tp=20 → all_done=0, max_offset=0.
  - Then assert rst mid-count → all_done=1 next cycle.

Source files
------------

// File: rtl/violated_timing_tracker_pkg.sv
// ---------------------------------------------------------------------------
// violated_timing_tracker_pkg
// Shared scheduler constants for the violated-timing tracker:
//   - RESTART_OVERWRITE / RESTART_MAX : restart-mode encodings selecting what
//     happens when a timer is re-armed while a count is still pending.
//   - vtt_clog2()                     : ceiling log2, used to size slot fields.
// ---------------------------------------------------------------------------
package violated_timing_tracker_pkg;

    // A new start replaces whatever count is pending.
    localparam int RESTART_OVERWRITE = 0;
    // A new start keeps the longer of the pending and the new count.
    localparam int RESTART_MAX       = 1;

    // Ceiling log2 for elaboration-time sizing; vtt_clog2(1) = 0.
    function automatic int vtt_clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (remaining > 0) begin
                result    = result + 1;
                remaining = remaining >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/violated_timing_timer.sv
// ---------------------------------------------------------------------------
// violated_timing_timer
// One DRAM timing-constraint channel. It holds the remaining count r, in DRAM
// cycles, measured from slot 0 of the current fabric cycle. Each fabric clock
// carries NCK_PER_CLK DRAM slots.
//
// Ports:
//   clk    : fabric clock
//   rst    : synchronous active-high reset; clears the pending count
//   start  : arm strobe for a command issued this fabric cycle
//   slot   : DRAM slot within the fabric cycle in which that command issued
//   tp     : constraint length in DRAM cycles
//   done   : constraint is met at or before some slot of the current cycle
//   offset : earliest legal slot this cycle; 0 when not done
// ---------------------------------------------------------------------------
module violated_timing_timer
    import violated_timing_tracker_pkg::*;
#(
    parameter int  NCK_PER_CLK  = 4,
    parameter int  TP_W         = 6,
    parameter int  RESTART_MODE = RESTART_OVERWRITE,
    localparam int SLOT_W       = vtt_clog2(NCK_PER_CLK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SLOT_W-1:0] slot,
    input  logic [TP_W-1:0]   tp,
    output logic              done,
    output logic [SLOT_W-1:0] offset
);

    localparam logic [TP_W:0] NCK_R = (TP_W + 1)'(NCK_PER_CLK);

    logic [TP_W:0] r_q;
    logic [TP_W:0] r_d;
    logic [TP_W:0] sum;
    logic [TP_W:0] load;
    logic [TP_W:0] dec;

    // The sum is one bit wider than tp. Since TP_W >= SLOT_W, the largest
    // slot + tp stays below 2^(TP_W+1) and cannot wrap. Subtracting one
    // fabric cycle's worth of slots accounts for the cycle the command
    // issued in.
    always_comb begin
        sum  = {1'b0, tp} + {{(TP_W + 1 - SLOT_W){1'b0}}, slot};
        load = (sum >= NCK_R) ? (sum - NCK_R) : '0;
        dec  = (r_q >= NCK_R) ? (r_q - NCK_R) : '0;
        r_d  = dec;
        if (start) begin
            if (RESTART_MODE == RESTART_MAX) begin
                r_d = (load > dec) ? load : dec;
            end else begin
                r_d = load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    // A remaining count below one fabric cycle means the constraint expires
    // inside this cycle. Its low bits give the first legal slot.
    assign done   = (r_q < NCK_R);
    assign offset = done ? r_q[SLOT_W-1:0] : '0;

endmodule

// File: rtl/violated_timing_tracker.sv
// ---------------------------------------------------------------------------
// violated_timing_tracker
// Multi-channel violated-timing tracker. It holds NUM_TIMERS independent DRAM
// timing constraints. It reports, per constraint and in aggregate, whether
// the constraint is met in the current fabric cycle and the earliest legal
// slot.
//
// Ports:
//   clk        : fabric clock
//   rst        : synchronous active-high reset
//   start      : per-timer arm strobe, one bit per timer
//   slot       : per-timer issue slot, timer i at [i*SLOT_W +: SLOT_W]
//   tp         : per-timer constraint length, timer i at [i*TP_W +: TP_W]
//   done       : per-timer satisfied flag
//   offset     : per-timer earliest legal slot, packed like slot
//   all_done   : every timer is satisfied
//   max_offset : latest of the per-timer offsets when all_done, else 0
// ---------------------------------------------------------------------------
module violated_timing_tracker
    import violated_timing_tracker_pkg::*;
#(
    parameter int  NCK_PER_CLK  = 4,
    parameter int  NUM_TIMERS   = 4,
    parameter int  TP_W         = 6,
    parameter int  RESTART_MODE = RESTART_OVERWRITE,
    localparam int SLOT_W       = vtt_clog2(NCK_PER_CLK)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_TIMERS-1:0]        start,
    input  logic [NUM_TIMERS*SLOT_W-1:0] slot,
    input  logic [NUM_TIMERS*TP_W-1:0]   tp,
    output logic [NUM_TIMERS-1:0]        done,
    output logic [NUM_TIMERS*SLOT_W-1:0] offset,
    output logic                         all_done,
    output logic [SLOT_W-1:0]            max_offset
);

    logic [SLOT_W-1:0] max_slot;

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_timer
        violated_timing_timer #(
            .NCK_PER_CLK  (NCK_PER_CLK),
            .TP_W         (TP_W),
            .RESTART_MODE (RESTART_MODE)
        ) u_timer (
            .clk    (clk),
            .rst    (rst),
            .start  (start[g]),
            .slot   (slot[g*SLOT_W +: SLOT_W]),
            .tp     (tp[g*TP_W +: TP_W]),
            .done   (done[g]),
            .offset (offset[g*SLOT_W +: SLOT_W])
        );
    end

    assign all_done = &done;

    // A multi-constraint command may issue only at the latest of the
    // per-timer earliest slots. That slot exists only when every timer
    // is done.
    always_comb begin
        max_slot = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (offset[i*SLOT_W +: SLOT_W] > max_slot) begin
                max_slot = offset[i*SLOT_W +: SLOT_W];
            end
        end
        max_offset = all_done ? max_slot : '0;
    end

endmodule

// File: tb/tb_violated_timing_tracker.sv
// ---------------------------------------------------------------------------
// tb_violated_timing_tracker
// Drives one overwrite-mode tracker and one max-mode tracker from the same
// stimulus. A reference model of the remaining counts predicts the outputs
// of each tracker for the following cycle and queues that prediction. The
// prediction is popped and compared once the clock edge has produced the
// outputs.
// ---------------------------------------------------------------------------
module tb_violated_timing_tracker;

    localparam int NCK = 4;
    localparam int NT  = 4;
    localparam int TPW = 6;
    localparam int SW  = 2;

    typedef struct packed {
        logic [NT-1:0]    done;
        logic [NT*SW-1:0] offset;
        logic             allDone;
        logic [SW-1:0]    maxOffset;
    } expect_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NT-1:0]    start;
    logic [NT*SW-1:0] slot;
    logic [NT*TPW-1:0] tp;

    logic [NT-1:0]    done0, done1;
    logic [NT*SW-1:0] offset0, offset1;
    logic             allDone0, allDone1;
    logic [SW-1:0]    maxOffset0, maxOffset1;

    int      rModel[2][NT];
    expect_t expQueue0[$];
    expect_t expQueue1[$];
    int      checkCount = 0;
    int      passCount  = 0;

    // 100 MHz fabric clock.
    always #5 clk = ~clk;

    violated_timing_tracker #(
        .NCK_PER_CLK(NCK), .NUM_TIMERS(NT), .TP_W(TPW), .RESTART_MODE(0)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start), .slot(slot), .tp(tp),
        .done(done0), .offset(offset0), .all_done(allDone0), .max_offset(maxOffset0)
    );

    violated_timing_tracker #(
        .NCK_PER_CLK(NCK), .NUM_TIMERS(NT), .TP_W(TPW), .RESTART_MODE(1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start), .slot(slot), .tp(tp),
        .done(done1), .offset(offset1), .all_done(allDone1), .max_offset(maxOffset1)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Reference next-state of one remaining count.
    function automatic int nextR(input int mode, input int r, input logic st,
                                 input int sl, input int t, input logic rs);
        int dec;
        int load;
        if (rs) return 0;
        dec  = (r >= NCK) ? r - NCK : 0;
        load = (sl + t >= NCK) ? sl + t - NCK : 0;
        if (!st) return dec;
        if (mode == 1) return (load > dec) ? load : dec;
        return load;
    endfunction

    // Outputs implied by the modelled counts of one tracker.
    function automatic expect_t predict(input int mode);
        expect_t e;
        int      mx;
        e  = '0;
        mx = 0;
        for (int i = 0; i < NT; i++) begin
            e.done[i] = (rModel[mode][i] < NCK);
            if (e.done[i]) begin
                e.offset[i*SW +: SW] = SW'(rModel[mode][i] % NCK);
                if (rModel[mode][i] % NCK > mx) mx = rModel[mode][i] % NCK;
            end
        end
        e.allDone   = &e.done;
        e.maxOffset = e.allDone ? SW'(mx) : '0;
        return e;
    endfunction

    task automatic compareOutputs();
        expect_t e;
        if (expQueue0.size() > 0) begin
            e = expQueue0.pop_front();
            checkOutput("m0_done",     32'(done0),      32'(e.done));
            checkOutput("m0_offset",   32'(offset0),    32'(e.offset));
            checkOutput("m0_all_done", 32'(allDone0),   32'(e.allDone));
            checkOutput("m0_max_off",  32'(maxOffset0), 32'(e.maxOffset));
        end
        if (expQueue1.size() > 0) begin
            e = expQueue1.pop_front();
            checkOutput("m1_done",     32'(done1),      32'(e.done));
            checkOutput("m1_offset",   32'(offset1),    32'(e.offset));
            checkOutput("m1_all_done", 32'(allDone1),   32'(e.allDone));
            checkOutput("m1_max_off",  32'(maxOffset1), 32'(e.maxOffset));
        end
    endtask

    // Drive one fabric cycle of stimulus on the falling edge. Queue the
    // predicted outputs, then compare just after the rising edge.
    task automatic applyStimulus(input logic rstV, input logic [NT-1:0] startV,
                                 input logic [NT*SW-1:0] slotV,
                                 input logic [NT*TPW-1:0] tpV);
        @(negedge clk);
        rst   = rstV;
        start = startV;
        slot  = slotV;
        tp    = tpV;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NT; i++) begin
                rModel[m][i] = nextR(m, rModel[m][i], startV[i],
                                     int'(slotV[i*SW +: SW]), int'(tpV[i*TPW +: TPW]), rstV);
            end
        end
        expQueue0.push_back(predict(0));
        expQueue1.push_back(predict(1));
        @(posedge clk);
        #1;
        compareOutputs();
    endtask

    task automatic armOne(input int idx, input int s, input int t);
        logic [NT-1:0]     st;
        logic [NT*SW-1:0]  sl;
        logic [NT*TPW-1:0] tv;
        st = '0;
        sl = '0;
        tv = '0;
        st[idx]             = 1'b1;
        sl[idx*SW +: SW]    = SW'(s);
        tv[idx*TPW +: TPW]  = TPW'(t);
        applyStimulus(1'b0, st, sl, tv);
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, '0);
    endtask

    initial begin
        logic [NT-1:0]     st;
        logic [NT*SW-1:0]  sl;
        logic [NT*TPW-1:0] tv;

        rst   = 1'b1;
        start = '0;
        slot  = '0;
        tp    = '0;
        for (int m = 0; m < 2; m++) for (int i = 0; i < NT; i++) rModel[m][i] = 0;

        // Reset state.
        applyStimulus(1'b1, '0, '0, '0);
        checkOutput("reset_done",     32'(done0),      32'hF);
        checkOutput("reset_all_done", 32'(allDone0),   32'h1);
        checkOutput("reset_max_off",  32'(maxOffset0), 32'h0);

        // Timer 0: slot 1, tp 6 loads 3.
        armOne(0, 1, 6);
        checkOutput("t0_done_load", 32'(done0[0]),     32'h1);
        checkOutput("t0_off_load",  32'(offset0[1:0]), 32'h3);
        idle();
        checkOutput("t0_off_drain", 32'(offset0[1:0]), 32'h0);

        // Timer 1: slot 2, tp 11 loads 9, done two cycles later at slot 1.
        armOne(1, 2, 11);
        checkOutput("t1_done_p1", 32'(done0[1]), 32'h0);
        idle();
        checkOutput("t1_done_p2", 32'(done0[1]), 32'h0);
        idle();
        checkOutput("t1_done_p3", 32'(done0[1]),     32'h1);
        checkOutput("t1_off_p3",  32'(offset0[3:2]), 32'h1);
        idle();
        checkOutput("t1_off_p4",  32'(offset0[3:2]), 32'h0);

        // Timer 2: short and zero constraints saturate to an immediate done.
        armOne(2, 2, 1);
        checkOutput("t2_sat_done", 32'(done0[2]),     32'h1);
        checkOutput("t2_sat_off",  32'(offset0[5:4]), 32'h0);
        armOne(2, 3, 0);
        checkOutput("t2_zero_off", 32'(offset0[5:4]), 32'h0);

        // Restart: the pending 7 decays to 3, and a new load saturates to 0.
        armOne(0, 0, 11);
        armOne(0, 0, 2);
        checkOutput("restart_m0_off", 32'(offset0[1:0]), 32'h0);
        checkOutput("restart_m1_done", 32'(done1[0]),    32'h1);
        checkOutput("restart_m1_off", 32'(offset1[1:0]), 32'h3);
        idle();

        // Aggregate: offsets 3 and 1 together, then a long timer 3, then reset.
        st = 4'b0011;
        sl = '0;
        tv = '0;
        sl[1:0] = 2'd1; tv[0 +: TPW]   = 6'd6;
        sl[3:2] = 2'd1; tv[TPW +: TPW] = 6'd4;
        applyStimulus(1'b0, st, sl, tv);
        checkOutput("agg_all_done", 32'(allDone0),   32'h1);
        checkOutput("agg_max_off",  32'(maxOffset0), 32'h3);
        armOne(3, 0, 20);
        checkOutput("agg_t3_all_done", 32'(allDone0),   32'h0);
        checkOutput("agg_t3_max_off",  32'(maxOffset0), 32'h0);
        idle();
        applyStimulus(1'b1, 4'b1000, '0, {6'd20, 18'd0});
        checkOutput("agg_rst_all_done", 32'(allDone0), 32'h1);
        checkOutput("agg_rst_all_done_m1", 32'(allDone1), 32'h1);

        // Largest tp issued in the last slot: 66 - 4 = 62, no wrap.
        armOne(0, 3, 63);
        checkOutput("max_tp_done", 32'(done0[0]), 32'h0);
        for (int k = 0; k < 15; k++) idle();
        checkOutput("max_tp_done_end", 32'(done0[0]),     32'h1);
        checkOutput("max_tp_off_end",  32'(offset0[1:0]), 32'h2);

        // Simultaneous starts on all timers with distinct loads.
        applyStimulus(1'b0, 4'b1111, {2'd3, 2'd2, 2'd1, 2'd0},
                      {6'd30, 6'd9, 6'd5, 6'd2});
        for (int k = 0; k < 8; k++) idle();

        // Random traffic with occasional reset.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(($urandom_range(0, 31) == 0), NT'($urandom),
                          (NT*SW)'($urandom), (NT*TPW)'($urandom));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
